// File: rtl/exe_div_unit_pkg.sv
// exe_div_unit_pkg: shared width, ALU op codes and FSM state type for the EXE divider
package exe_div_unit_pkg;
  localparam int DIV_WIDTH = 32;
  localparam logic [3:0] OP_DIV = 4'hA;
  localparam logic [3:0] OP_DIVU = 4'hB;
  typedef enum logic [1:0] {DIV_IDLE, DIV_CALC, DIV_DONE} div_state_t;
endpackage

// File: rtl/exe_div_unit_step.sv
// exe_div_unit_step: one restoring-division iteration (shift, compare, conditional subtract)
module exe_div_unit_step
  import exe_div_unit_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] dvd,
  input  logic [WIDTH-1:0] dvs,
  output logic [WIDTH-1:0] rem_n,
  output logic [WIDTH-1:0] dvd_n,
  output logic             qbit
);
  logic [WIDTH:0] sh;
  assign sh = {rem, dvd[WIDTH-1]};
  assign qbit = sh >= {1'b0, dvs};
  // rem < dvs keeps sh < 2*dvs, so the difference always fits in WIDTH bits
  assign rem_n = qbit ? sh[WIDTH-1:0] - dvs : sh[WIDTH-1:0];
  assign dvd_n = {dvd[WIDTH-2:0], 1'b0};
endmodule

// File: rtl/exe_div_unit.sv
// exe_div_unit: multi-cycle signed/unsigned restoring divider that stalls ID/EXE until the result is ready
module exe_div_unit
  import exe_div_unit_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             EXE_DivStart,
  input  logic             EXE_DivSign,
  input  logic [WIDTH-1:0] EXE_BusA,
  input  logic [WIDTH-1:0] EXE_BusB,
  input  logic             EXE_Flush,
  output logic             EXE_DivBusy,
  output logic             Div_Done,
  output logic [WIDTH-1:0] Div_Quot,
  output logic [WIDTH-1:0] Div_Rem
);
  localparam int CNT_W = $clog2(WIDTH);
  div_state_t state, state_n;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] acc, dvd, dvs, quo, a_raw, acc_n, dvd_n, quo_n;
  logic q_neg, r_neg, dz, qbit, launch, last;
  exe_div_unit_step #(.WIDTH(WIDTH)) u_step (
    .rem  (acc),
    .dvd  (dvd),
    .dvs  (dvs),
    .rem_n(acc_n),
    .dvd_n(dvd_n),
    .qbit (qbit)
  );
  assign quo_n = {quo[WIDTH-2:0], qbit};
  assign launch = state == DIV_IDLE && EXE_DivStart && !EXE_Flush;
  assign last = state == DIV_CALC && cnt == CNT_W'(WIDTH - 1);
  assign EXE_DivBusy = launch || state == DIV_CALC;
  assign Div_Done = state == DIV_DONE && !EXE_Flush;
  always_comb begin
    state_n = EXE_Flush ? DIV_IDLE :
              launch    ? DIV_CALC :
              last      ? DIV_DONE :
              state == DIV_CALC ? DIV_CALC : DIV_IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= DIV_IDLE;
      cnt      <= '0;
      acc      <= '0;
      dvd      <= '0;
      dvs      <= '0;
      quo      <= '0;
      a_raw    <= '0;
      q_neg    <= 1'b0;
      r_neg    <= 1'b0;
      dz       <= 1'b0;
      Div_Quot <= '0;
      Div_Rem  <= '0;
    end else begin
      state <= state_n;
      if (launch) begin
        cnt   <= '0;
        acc   <= '0;
        quo   <= '0;
        dvd   <= EXE_DivSign && EXE_BusA[WIDTH-1] ? -EXE_BusA : EXE_BusA;
        dvs   <= EXE_DivSign && EXE_BusB[WIDTH-1] ? -EXE_BusB : EXE_BusB;
        a_raw <= EXE_BusA;
        dz    <= EXE_BusB == '0;
        q_neg <= EXE_DivSign && (EXE_BusA[WIDTH-1] ^ EXE_BusB[WIDTH-1]);
        r_neg <= EXE_DivSign && EXE_BusA[WIDTH-1];
      end else if (state == DIV_CALC) begin
        cnt <= cnt + 1'b1;
        acc <= acc_n;
        dvd <= dvd_n;
        quo <= quo_n;
        // divide-by-zero bypasses sign fixup so Q stays all ones and R is the raw dividend
        if (last && !EXE_Flush) begin
          Div_Quot <= dz ? '1 : q_neg ? -quo_n : quo_n;
          Div_Rem  <= dz ? a_raw : r_neg ? -acc_n : acc_n;
        end
      end
    end
  end
endmodule

// File: tb/tb_exe_div_unit.sv
// tb_exe_div_unit: directed divider tests checked every cycle against a cycle-count reference model
module tb_exe_div_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0, sign = 1'b0, flush = 1'b0;
  logic [31:0] a = '0, b = '0;
  logic busy, done;
  logic [31:0] quot, rem;
  int passes = 0, total = 0;
  int cyc = 0;
  int age = 0;
  bit armed = 0;
  logic [31:0] pq = '0, pr = '0, mq = '0, mr = '0;

  exe_div_unit dut (
    .clk(clk), .rst(rst), .EXE_DivStart(start), .EXE_DivSign(sign),
    .EXE_BusA(a), .EXE_BusB(b), .EXE_Flush(flush),
    .EXE_DivBusy(busy), .Div_Done(done), .Div_Quot(quot), .Div_Rem(rem)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] ref_div(input logic [31:0] x, input logic [31:0] y, input logic s);
    if (y == 0) return {32'hFFFF_FFFF, x};
    if (s && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return {32'h8000_0000, 32'h0};
    if (s) return {32'($signed(x) / $signed(y)), 32'($signed(x) % $signed(y))};
    return {x / y, x % y};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passes++;
    else $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc, act, exp);
  endtask

  // age counts cycles since launch: 1..32 computing, 33 result cycle
  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      age = 0; mq = '0; mr = '0;
    end else if (age == 0) begin
      if (start && !flush) begin
        age = 1;
        {pq, pr} = ref_div(a, b, sign);
      end
    end else if (flush || age == 33) begin
      age = 0;
    end else begin
      age++;
      if (age == 33) begin mq = pq; mr = pr; end
    end
    armed = 1;
  end

  always @(negedge clk) begin
    if (armed) begin
      chk("busy", 32'(busy), 32'((age == 0 && start && !flush) || (age >= 1 && age <= 32)));
      chk("done", 32'(done), 32'(age == 33 && !flush));
      chk("quot", quot, mq);
      chk("rem", rem, mr);
    end
  end

  task automatic do_div(input logic [31:0] x, input logic [31:0] y, input logic s,
                        input logic [31:0] eq, input logic [31:0] er, input bit hold);
    int n;
    @(posedge clk); #1;
    a = x; b = y; sign = s; start = 1'b1;
    for (n = 0; n < 50; n++) begin
      @(negedge clk);
      if (done) break;
      @(posedge clk); #1;
      if (!hold) start = 1'b0;
    end
    chk("latency", n, 33);
    chk("lit_quot", quot, eq);
    chk("lit_rem", rem, er);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_quot", quot, 0);
    chk("reset_busy", 32'(busy), 0);
    do_div(32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 0);
    do_div(-32'sd7, 32'd2, 1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 0);
    do_div(32'd7, -32'sd2, 1'b1, 32'hFFFF_FFFD, 32'd1, 0);
    do_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'h0, 0);
    do_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'h0, 32'h8000_0000, 0);
    do_div(32'h1234, 32'h0, 1'b0, 32'hFFFF_FFFF, 32'h1234, 0);
    do_div(-32'sd5, 32'h0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFB, 0);
    // flush at T+10, restart at T+12
    @(posedge clk); #1;
    a = 32'd50; b = 32'd6; sign = 1'b0; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (9) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0;
    @(negedge clk);
    chk("flush_busy", 32'(busy), 0);
    chk("flush_done", 32'(done), 0);
    do_div(32'd9, 32'd3, 1'b0, 32'd3, 32'd0, 0);
    // start held through the result cycle, then relaunch, then reset mid-op
    do_div(32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("relaunch_busy", 32'(busy), 1);
    @(posedge clk); #1 start = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_quot", quot, 0);
    chk("rst_rem", rem, 0);
    repeat (40) @(posedge clk);
    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end
endmodule
